move_extractor: RTL
===================

# move_extractor

Reads two board snapshots (before and after a move) square by square and reconstructs the move descriptor consumed by `board_updater`: from/to one-hot positions, moving and captured piece, castling and en-passant codes. Sits between the board register file (or the human-move sensing path) and the engine/undo logic. It is the inverse of the board update path: the updater turns a descriptor into square writes, and this block turns square contents back into a descriptor.

## Interface
Parameters: none. All codes are fixed in the shared package.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `moverColor`  in  1  colour bit of the side that moved (0 = white).
- `rd_en`  out  1  high while a square address is issued.
- `sq_addr`  out  6  square index (rank*8+file, 0 = a1).
- `old_piece`  in  6  pre-move contents of `sq_addr`; valid one cycle after `rd_en`.
- `new_piece`  in  6  post-move contents; same timing as `old_piece`.
- `busy`  out  1  scan or classify in progress.
- `valid`  out  1  one-cycle pulse; descriptor outputs are final.
- `error`  out  1  qualified by `valid`; change pattern is not a legal move shape.
- `initialPosition`  out  64  one-hot from-square.
- `movedPosition`  out  64  one-hot to-square.
- `movingPiece`  out  6  one-hot: 000001 pawn, 000010 rook, 000100 knight, 001000 bishop, 010000 queen, 100000 king.
- `capturedPiece`  out  6  same one-hot code; 000000 = quiet move.
- `castling`  out  3  001 none, 010 queen side, 100 king side.
- `enpassant`  out  5  00001 none, 00010 UL, 00100 UR, 01000 DL, 10000 DR.

## Operation
- Piece word is {colour, type[4:0]}. Type codes: PAWN 00010, KNIGHT 00001, KING 00100, QUEEN 11000, ROOK 10000, BISHOP 01000. 000000 = empty. A square is occupied when type ≠ 0.
- FSM states:
  - IDLE → SCAN on `start`.
  - SCAN issues addresses 0..63, one per cycle, then → DRAIN.
  - DRAIN captures the final data beat → CLASSIFY.
  - CLASSIFY runs one cycle → DONE.
  - DONE pulses `valid` → IDLE.
- Per returned square where old ≠ new, classify:
  - VO (own vacated): old is own colour, new is empty.
  - AO (own arrived): new is own colour.
  - VX (opponent vacated): old is opponent, new is empty.
  - Any other change is illegal.
- Storage: up to 2 VO and 2 AO records and 1 VX record, each {index, old type, new type}. Overflow or an illegal change sets a sticky error flag.
- Classification:
  - 1 VO + 1 AO, no VX → normal move. From = VO, to = AO. `movingPiece` comes from the VO old type, so a promotion reports pawn. `capturedPiece` comes from the AO old type if that is an opponent piece, else 000000.
  - 2 VO + 2 AO, one king and one rook, king vacated from file e → castling. King to file g gives 100; file c gives 010. Positions are the king's squares. `movingPiece` = king.
  - 1 VO pawn + 1 AO pawn onto an empty square + 1 VX pawn → en passant. Code from to − from: +7 UL, +9 UR, −9 DL, −7 DR. `capturedPiece` = pawn.
  - Anything else, including zero changes → error.
- On error: positions 0, pieces 0, `castling` 001, `enpassant` 00001.
- Outputs hold until the next `start` is accepted; they are cleared to reset values when that `start` is accepted.

## Timing
- `start` sampled at edge t. `rd_en` = 1 and `sq_addr` = k in cycle t+1+k, for k = 0..63.
- Data for address k is registered at the end of cycle t+2+k. The last beat arrives in cycle t+65 (DRAIN).
- CLASSIFY in cycle t+66. `valid` is high in cycle t+67 only.
- `busy` is high in cycles t+1..t+67.
- `start` while `busy` is ignored.
- A simultaneous `clear` and `start` gives `clear` priority.
- Reset values:
  - `rd_en`, `sq_addr`, `busy`, `valid`, `error` = 0.
  - Positions and pieces = 0.
  - `castling` = 001, `enpassant` = 00001.
- `clear` mid-scan: all outputs take reset values the next cycle, partial records are discarded, and no `valid` is produced.

## Structure
- Package `chess_pkg`: piece type codes, empty code, one-hot piece/castling/en-passant codes, FSM state enum.
- One combinational sub-module, `square_diff_classifier`:
  - inputs: old, new, `moverColor`.
  - outputs: VO/AO/VX/illegal flags.
- Sequential record capture, FSM and final decode stay in `move_extractor`.

## Test plan
- Quiet move: white pawn 12→28, `moverColor` 0 → `initialPosition` = 1<<12, `movedPosition` = 1<<28, `movingPiece` 000001, `capturedPiece` 000000, `castling` 001, `enpassant` 00001, `valid` at t+67.
- Capture: white knight 6→21 onto a black bishop → `capturedPiece` 001000, `movingPiece` 000100, `error` 0.
- King-side castle: king 4→6, rook 7→5 → `castling` 100, positions 1<<4 and 1<<6, `movingPiece` 100000.
- En passant: white pawn 36→43, black pawn vacates 35 → `enpassant` 00010, `capturedPiece` 000001.
- Identical boards → `valid` with `error` 1 and all descriptor outputs at their defaults.
- `clear` at t+30 → `busy` 0 at t+31, no `valid`. `start` pulsed during a scan is ignored. A restart after `clear` completes at its own t+67.

Source files
------------

// File: rtl/move_extractor_pkg.sv
// Shared chess codes for the move extractor slice.
// Piece words are {colour, type[4:0]}.
package chess_pkg;

  localparam logic [4:0] T_EMPTY  = 5'b00000;
  localparam logic [4:0] T_KNIGHT = 5'b00001;
  localparam logic [4:0] T_PAWN   = 5'b00010;
  localparam logic [4:0] T_KING   = 5'b00100;
  localparam logic [4:0] T_BISHOP = 5'b01000;
  localparam logic [4:0] T_ROOK   = 5'b10000;
  localparam logic [4:0] T_QUEEN  = 5'b11000;

  localparam logic [5:0] P_NONE   = 6'b000000;
  localparam logic [5:0] P_PAWN   = 6'b000001;
  localparam logic [5:0] P_ROOK   = 6'b000010;
  localparam logic [5:0] P_KNIGHT = 6'b000100;
  localparam logic [5:0] P_BISHOP = 6'b001000;
  localparam logic [5:0] P_QUEEN  = 6'b010000;
  localparam logic [5:0] P_KING   = 6'b100000;

  localparam logic [2:0] C_NONE = 3'b001;
  localparam logic [2:0] C_QS   = 3'b010;
  localparam logic [2:0] C_KS   = 3'b100;

  localparam logic [4:0] EP_NONE = 5'b00001;
  localparam logic [4:0] EP_UL   = 5'b00010;
  localparam logic [4:0] EP_UR   = 5'b00100;
  localparam logic [4:0] EP_DL   = 5'b01000;
  localparam logic [4:0] EP_DR   = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_CLASSIFY,
    S_DONE
  } state_t;

  function automatic logic [5:0] pieceOneHot(
    input logic [4:0] t
  );
    case (t)
      T_PAWN:   return P_PAWN;
      T_ROOK:   return P_ROOK;
      T_KNIGHT: return P_KNIGHT;
      T_BISHOP: return P_BISHOP;
      T_QUEEN:  return P_QUEEN;
      T_KING:   return P_KING;
      default:  return P_NONE;
    endcase
  endfunction

endpackage

// File: rtl/move_extractor_if.sv
// Board snapshot read port: address out, old/new square
// contents back one cycle later.
interface move_extractor_if;
  logic       rd_en;
  logic [5:0] sq_addr;
  logic [5:0] old_piece;
  logic [5:0] new_piece;

  modport master (
    output rd_en, sq_addr,
    input  old_piece, new_piece
  );

  modport slave (
    input  rd_en, sq_addr,
    output old_piece, new_piece
  );
endinterface

// File: rtl/move_extractor_classifier.sv
// Per-square change classifier: own vacated, own arrived,
// opponent vacated, or an illegal change.
module square_diff_classifier
  import chess_pkg::*;
(
  input  logic [5:0] oldPiece,
  input  logic [5:0] newPiece,
  input  logic       moverColor,
  output logic       isVo,
  output logic       isAo,
  output logic       isVx,
  output logic       illegal
);
  logic changed;
  logic oldOcc;
  logic newOcc;

  assign changed = oldPiece != newPiece;
  assign oldOcc  = oldPiece[4:0] != T_EMPTY;
  assign newOcc  = newPiece[4:0] != T_EMPTY;

  assign isVo = changed && oldOcc && !newOcc &&
                oldPiece[5] == moverColor;
  assign isAo = changed && newOcc &&
                newPiece[5] == moverColor;
  assign isVx = changed && oldOcc && !newOcc &&
                oldPiece[5] != moverColor;
  assign illegal = changed && !(isVo || isAo || isVx);
endmodule

// File: rtl/move_extractor.sv
// Scans before/after boards and rebuilds the move
// descriptor consumed by the board updater.
module move_extractor
  import chess_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              moverColor,
  move_extractor_if.master  bus,
  output logic              busy,
  output logic              valid,
  output logic              error,
  output logic [63:0]       initialPosition,
  output logic [63:0]       movedPosition,
  output logic [5:0]        movingPiece,
  output logic [5:0]        capturedPiece,
  output logic [2:0]        castling,
  output logic [4:0]        enpassant
);
  state_t     state, nextState;
  logic [5:0] addr, capAddr;
  logic       capV, errFlag;
  logic [1:0] voCnt, aoCnt;
  logic       vxCnt;
  logic [5:0] voIdx [2];
  logic [4:0] voType [2];
  logic [5:0] aoIdx [2];
  logic [4:0] aoType [2];
  logic [5:0] aoOld0, vxIdx;
  logic [4:0] vxType;
  logic       isVo, isAo, isVx, illegal;

  square_diff_classifier u_cls (
    .oldPiece   (bus.old_piece),
    .newPiece   (bus.new_piece),
    .moverColor (moverColor),
    .isVo       (isVo),
    .isAo       (isAo),
    .isVx       (isVx),
    .illegal    (illegal)
  );

  assign bus.rd_en   = state == S_SCAN;
  assign bus.sq_addr = addr;
  assign busy        = state != S_IDLE;
  assign valid       = state == S_DONE;

  always_comb begin
    nextState = state;
    unique case (state)
      S_IDLE:     if (start) nextState = S_SCAN;
      S_SCAN:     if (addr == 6'd63) nextState = S_DRAIN;
      S_DRAIN:    nextState = S_CLASSIFY;
      S_CLASSIFY: nextState = S_DONE;
      S_DONE:     nextState = S_IDLE;
      default:    nextState = S_IDLE;
    endcase
  end

  // Final decode from the captured records
  logic       kv0, ka0, kvOk, kaOk;
  logic [5:0] kvIdx, kaIdx;
  logic [4:0] rvType, raType;
  logic [6:0] epDiff;
  logic [4:0] epCode;
  logic       isNormal, isCastle, isEp;
  logic       castleOk, epOk, capOpp;

  assign kv0    = voType[0] == T_KING;
  assign kvOk   = kv0 || voType[1] == T_KING;
  assign kvIdx  = kv0 ? voIdx[0] : voIdx[1];
  assign rvType = kv0 ? voType[1] : voType[0];
  assign ka0    = aoType[0] == T_KING;
  assign kaOk   = ka0 || aoType[1] == T_KING;
  assign kaIdx  = ka0 ? aoIdx[0] : aoIdx[1];
  assign raType = ka0 ? aoType[1] : aoType[0];
  assign epDiff = {1'b0, aoIdx[0]} - {1'b0, voIdx[0]};

  always_comb begin
    case (epDiff)
      7'd7:    epCode = EP_UL;
      7'd9:    epCode = EP_UR;
      7'h77:   epCode = EP_DL;
      7'h79:   epCode = EP_DR;
      default: epCode = EP_NONE;
    endcase
  end

  assign isNormal = !errFlag && voCnt == 2'd1 &&
                    aoCnt == 2'd1 && !vxCnt;
  assign isCastle = !errFlag && voCnt == 2'd2 &&
                    aoCnt == 2'd2 && !vxCnt;
  assign isEp     = !errFlag && voCnt == 2'd1 &&
                    aoCnt == 2'd1 && vxCnt;
  assign castleOk = kvOk && kaOk &&
                    rvType == T_ROOK &&
                    raType == T_ROOK &&
                    kvIdx[2:0] == 3'd4 &&
                    kaIdx[5:3] == kvIdx[5:3] &&
                    (kaIdx[2:0] == 3'd6 ||
                     kaIdx[2:0] == 3'd2);
  assign epOk = voType[0] == T_PAWN &&
                aoType[0] == T_PAWN &&
                aoOld0[4:0] == T_EMPTY &&
                vxType == T_PAWN &&
                vxIdx == {voIdx[0][5:3], aoIdx[0][2:0]} &&
                epCode != EP_NONE;
  assign capOpp = aoOld0[4:0] != T_EMPTY &&
                  aoOld0[5] != moverColor;

  logic       dErr;
  logic [5:0] dFrom, dTo, dMov, dCap;
  logic [2:0] dCast;
  logic [4:0] dEp;

  always_comb begin
    dErr  = 1'b1;
    dFrom = '0;
    dTo   = '0;
    dMov  = P_NONE;
    dCap  = P_NONE;
    dCast = C_NONE;
    dEp   = EP_NONE;
    unique case (1'b1)
      isNormal: begin
        dMov  = pieceOneHot(voType[0]);
        dErr  = dMov == P_NONE;
        dFrom = voIdx[0];
        dTo   = aoIdx[0];
        if (capOpp) dCap = pieceOneHot(aoOld0[4:0]);
      end
      isCastle: begin
        dErr  = !castleOk;
        dFrom = kvIdx;
        dTo   = kaIdx;
        dMov  = P_KING;
        dCast = (kaIdx[2:0] == 3'd6) ? C_KS : C_QS;
      end
      isEp: begin
        dErr  = !epOk;
        dFrom = voIdx[0];
        dTo   = aoIdx[0];
        dMov  = P_PAWN;
        dCap  = P_PAWN;
        dEp   = epCode;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state           <= S_IDLE;
      addr            <= '0;
      capAddr         <= '0;
      capV            <= 1'b0;
      voCnt           <= '0;
      aoCnt           <= '0;
      vxCnt           <= 1'b0;
      errFlag         <= 1'b0;
      error           <= 1'b0;
      initialPosition <= '0;
      movedPosition   <= '0;
      movingPiece     <= P_NONE;
      capturedPiece   <= P_NONE;
      castling        <= C_NONE;
      enpassant       <= EP_NONE;
    end else begin
      state   <= nextState;
      capV    <= state == S_SCAN;
      capAddr <= addr;
      if (state == S_SCAN) addr <= addr + 6'd1;
      if (state == S_IDLE && start) begin
        voCnt           <= '0;
        aoCnt           <= '0;
        vxCnt           <= 1'b0;
        errFlag         <= 1'b0;
        error           <= 1'b0;
        initialPosition <= '0;
        movedPosition   <= '0;
        movingPiece     <= P_NONE;
        capturedPiece   <= P_NONE;
        castling        <= C_NONE;
        enpassant       <= EP_NONE;
      end
      if (capV) begin
        if (illegal) errFlag <= 1'b1;
        if (isVo) begin
          if (voCnt == 2'd2) errFlag <= 1'b1;
          else begin
            voIdx[voCnt[0]]  <= capAddr;
            voType[voCnt[0]] <= bus.old_piece[4:0];
            voCnt            <= voCnt + 2'd1;
          end
        end
        if (isAo) begin
          if (aoCnt == 2'd2) errFlag <= 1'b1;
          else begin
            aoIdx[aoCnt[0]]  <= capAddr;
            aoType[aoCnt[0]] <= bus.new_piece[4:0];
            if (aoCnt == 2'd0) aoOld0 <= bus.old_piece;
            aoCnt            <= aoCnt + 2'd1;
          end
        end
        if (isVx) begin
          if (vxCnt) errFlag <= 1'b1;
          else begin
            vxIdx  <= capAddr;
            vxType <= bus.old_piece[4:0];
            vxCnt  <= 1'b1;
          end
        end
      end
      if (state == S_CLASSIFY) begin
        error           <= dErr;
        initialPosition <= dErr ? '0 : 64'd1 << dFrom;
        movedPosition   <= dErr ? '0 : 64'd1 << dTo;
        movingPiece     <= dErr ? P_NONE : dMov;
        capturedPiece   <= dErr ? P_NONE : dCap;
        castling        <= dErr ? C_NONE : dCast;
        enpassant       <= dErr ? EP_NONE : dEp;
      end
    end
  end
endmodule
